// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between a byte FIFO and the UART transmitter.
interface fifo_uart_tx_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_read;
  logic       fifo_enable;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_read,
    output fifo_enable
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_read,
    input  fifo_enable
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an external FIFO and counts finished frames.
//   state | meaning
//   IDLE  | line high, waiting for tx_enable with a non-empty FIFO
//   READ  | one-cycle pop strobe to the FIFO
//   FETCH | FIFO output now valid, byte captured at end of cycle
//   START | start bit (low)
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high), frame counted on its last cycle
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           tx_enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic [15:0]    sent_count
);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_TC = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FETCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t            state;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_idx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [15:0]       sent_count_q;
  logic              baud_done;

  assign baud_done  = (baud_cnt == '0);
  assign sent_count = sent_count_q;

  // The captured byte is indexed rather than shifted so it stays intact for the whole frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      tx               <= 1'b1;
      fifo.fifo_read   <= 1'b0;
      fifo.fifo_enable <= 1'b0;
      busy             <= 1'b0;
      sent_count_q     <= '0;
      shift_reg        <= '0;
      bit_idx          <= '0;
      baud_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_enable && !fifo.fifo_empty) begin
            state            <= READ;
            fifo.fifo_read   <= 1'b1;
            fifo.fifo_enable <= 1'b1;
            busy             <= 1'b1;
          end
        end
        READ: begin
          state            <= FETCH;
          fifo.fifo_read   <= 1'b0;
          fifo.fifo_enable <= 1'b0;
        end
        FETCH: begin
          state     <= START;
          shift_reg <= fifo.fifo_data;
          tx        <= 1'b0;
          baud_cnt  <= BAUD_TC;
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            tx       <= shift_reg[0];
            bit_idx  <= '0;
            baud_cnt <= BAUD_TC;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_TC;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sent_count_q <= sent_count_q + 16'd1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state            <= IDLE;
          tx               <= 1'b1;
          fifo.fifo_read   <= 1'b0;
          fifo.fifo_enable <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: a FIFO model feeds the transmitter, a UART line decoder checks frames.
module tb_fifo_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int BUSY_LEN = 2 + FRAME;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tx_enable = 1'b0;
  logic        tx;
  logic        busy;
  logic [15:0] sent_count;

  fifo_uart_tx_if ifc ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo       (ifc.master),
    .tx         (tx),
    .busy       (busy),
    .sent_count (sent_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int frames_started = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int gap_q[$];
  int busy_q[$];
  bit noise_en = 1'b0;
  bit mon_active = 1'b0;
  int mon_cnt = 0;
  logic [15:0] sent_model = 16'd0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO model: pop on the edge that ends the strobe cycle, data held through FETCH
  initial begin : fifo_model
    bit rd, prev_rd, hold;
    prev_rd = 1'b0;
    hold = 1'b0;
    ifc.fifo_data = 8'h00;
    ifc.fifo_empty = 1'b1;
    forever begin
      @(negedge clock);
      rd = ifc.fifo_read;
      if (ifc.fifo_read === 1'b1 || ifc.fifo_enable === 1'b1) begin
        chk("enable_with_read", ifc.fifo_enable, ifc.fifo_read);
        chk("strobe_len", prev_rd && rd, 0);
      end
      prev_rd = rd;
      if (hold) hold = 1'b0;
      else if (noise_en) ifc.fifo_data = 8'($urandom);
      ifc.fifo_empty = (fifo_q.size() == 0);
      @(posedge clock);
      #1;
      if (rd) begin
        strobes++;
        chk("read_nonempty", fifo_q.size() > 0, 1);
        if (fifo_q.size() > 0) ifc.fifo_data = fifo_q.pop_front();
        hold = 1'b1;
      end
      ifc.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // UART line decoder and busy-length monitor
  initial begin : uart_mon
    logic samp [0:FRAME-1];
    int gap, busy_run;
    bit shape_ok;
    logic [7:0] got;
    gap = 0;
    busy_run = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_active = 1'b0;
        mon_cnt = 0;
        gap = 0;
        busy_run = 0;
      end else begin
        if (busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin
          busy_q.push_back(busy_run);
          busy_run = 0;
        end
        if (!mon_active) begin
          if (tx === 1'b0) begin
            mon_active = 1'b1;
            samp[0] = 1'b0;
            mon_cnt = 1;
            gap_q.push_back(gap);
            frames_started++;
          end else if (gap < 1000) begin
            gap++;
          end
        end else begin
          samp[mon_cnt] = tx;
          mon_cnt++;
          if (mon_cnt == FRAME) begin
            shape_ok = (samp[0] === 1'b0) && (samp[9*CPB] === 1'b1);
            for (int g = 0; g < 10; g++)
              for (int k = 1; k < CPB; k++)
                if (samp[g*CPB+k] !== samp[g*CPB]) shape_ok = 1'b0;
            chk("frame_shape", shape_ok, 1);
            for (int b = 0; b < 8; b++) got[b] = samp[(b+1)*CPB];
            chk("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("frame_byte", got, exp_q.pop_front());
            chk("busy_in_frame", busy, 1);
            mon_active = 1'b0;
            mon_cnt = 0;
            gap = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_exp(logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_mon(string name, int cnt);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      if (mon_active && mon_cnt == cnt) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  task automatic drain(string name, int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !mon_active && busy === 1'b0) done = 1'b1;
    end
    chk({name, "_done"}, exp_q.size(), 0);
    cyc(3);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin : stim
    int s0, f0;
    logic [7:0] burst [7];
    logic [7:0] rb;
    burst = '{8'h01, 8'h02, 8'h04, 8'h80, 8'hFF, 8'h70, 8'h2C};

    // reset values
    cyc(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read", ifc.fifo_read, 0);
    chk("rst_enable", ifc.fifo_enable, 0);
    chk("rst_count", sent_count, 0);
    reset = 1'b0;
    cyc(2);

    // enabled but empty: line stays idle
    tx_enable = 1'b1;
    cyc(20);
    chk("empty_strobes", strobes, 0);
    chk("empty_frames", frames_started, 0);
    chk("empty_tx", tx, 1);
    chk("empty_busy", busy, 0);

    // single byte
    busy_q.delete();
    s0 = strobes;
    push_exp(8'h01);
    drain("single", 150);
    sent_model++;
    chk("single_strobes", strobes - s0, 1);
    chk("single_count", sent_count, sent_model);
    chk("single_busy_runs", busy_q.size(), 1);
    if (busy_q.size() > 0) chk("single_busy_len", busy_q[0], BUSY_LEN);

    // back-to-back burst
    gap_q.delete();
    busy_q.delete();
    s0 = strobes;
    foreach (burst[i]) push_exp(burst[i]);
    drain("burst", 7*(FRAME+5) + 50);
    sent_model += 7;
    chk("burst_strobes", strobes - s0, 7);
    chk("burst_count", sent_count, sent_model);
    chk("burst_empty", ifc.fifo_empty, 1);
    chk("burst_frames", gap_q.size(), 7);
    for (int i = 1; i < gap_q.size(); i++) chk("burst_gap", gap_q[i], 3);
    chk("burst_busy_runs", busy_q.size(), 7);
    foreach (busy_q[i]) chk("burst_busy_len", busy_q[i], BUSY_LEN);

    // disabled with data waiting, then enabled
    tx_enable = 1'b0;
    s0 = strobes;
    f0 = frames_started;
    push_exp(8'h02);
    push_exp(8'h03);
    cyc(30);
    chk("dis_strobes", strobes - s0, 0);
    chk("dis_frames", frames_started - f0, 0);
    chk("dis_tx", tx, 1);
    chk("dis_count", sent_count, sent_model);
    tx_enable = 1'b1;
    drain("dis", 2*(FRAME+5) + 50);
    sent_model += 2;
    chk("dis_strobes_after", strobes - s0, 2);
    chk("dis_count_after", sent_count, sent_model);

    // enable falls during data bit 3
    s0 = strobes;
    push_exp(8'h55);
    fifo_q.push_back(8'h66);
    wait_mon("drop_wait", 4*CPB + 2);
    tx_enable = 1'b0;
    drain("drop", FRAME + 50);
    cyc(20);
    sent_model++;
    chk("drop_strobes", strobes - s0, 1);
    chk("drop_left", fifo_q.size(), 1);
    chk("drop_count", sent_count, sent_model);
    fifo_q.delete();
    cyc(2);
    tx_enable = 1'b1;

    // random bytes, irregular arrival, noisy FIFO output between pops
    noise_en = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      push_exp(rb);
      cyc($urandom_range(0, 60));
    end
    drain("rand", 6*(FRAME+5) + 100);
    noise_en = 1'b0;
    sent_model += 6;
    chk("rand_strobes", strobes - s0, 6);
    chk("rand_count", sent_count, sent_model);

    // reset pulse during data bit 5
    s0 = strobes;
    push_exp(8'hA7);
    push_exp(8'h3C);
    wait_mon("rst_wait", 6*CPB + 2);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_tx", tx, 1);
    chk("midrst_count", sent_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_read", ifc.fifo_read, 0);
    @(negedge clock);
    reset = 1'b0;
    void'(exp_q.pop_front());
    sent_model = 16'd1;
    drain("midrst", FRAME + 60);
    chk("midrst_count_after", sent_count, sent_model);
    chk("midrst_strobes", strobes - s0, 2);

    // counter wrap from a preset of 0xFFFF
    force dut.sent_count_q = 16'hFFFF;
    cyc(1);
    release dut.sent_count_q;
    cyc(1);
    sent_model = 16'hFFFF;
    push_exp(8'hC3);
    drain("wrap", FRAME + 50);
    sent_model = sent_model + 16'd1;
    chk("wrap_count", sent_count, sent_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 868, clock cycles per serial bit; legal range 2..65535.
REQ-002 Ports: clock  input  1  single clock; all logic rising-edge.
REQ-003 Ports: reset  input  1  synchronous, active-high reset.
REQ-004 Ports: tx_enable  input  1  permits fetching and sending new bytes.
REQ-005 Ports: fifo_data  input  8  byte from FIFO data_out.
REQ-006 Ports: fifo_empty  input  1  FIFO empty flag.
REQ-007 Ports: fifo_read  output  1  one-cycle FIFO read strobe.
REQ-008 Ports: fifo_enable  output  1  FIFO enable, asserted together with fifo_read.
REQ-009 Ports: tx  output  1  UART 8N1 serial line, idle high.
REQ-010 Ports: busy  output  1  high in every state except IDLE.
REQ-011 Ports: sent_count  output  16  count of completed frames.

Function
REQ-012 The block SHALL implement the states IDLE, READ, FETCH, START, DATA and STOP.
REQ-013 IDLE -> READ when tx_enable=1 and fifo_empty=0, sampled in IDLE only; otherwise remain in IDLE.
REQ-014 READ SHALL last exactly 1 cycle with fifo_read=1 and fifo_enable=1; both SHALL be 0 in every other state.
REQ-015 FETCH SHALL last 1 cycle and latch fifo_data into an 8-bit shift register at its end (data valid 1 cycle after the strobe); FETCH -> START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles; then DATA.
REQ-017 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7 -> STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; at its last cycle sent_count += 1 (wraps 0xFFFF -> 0x0000) and -> IDLE.
REQ-019 tx SHALL be registered, with no combinational path from any input to tx.
REQ-020 Back-to-back frames: the last stop-bit cycle is followed by exactly 3 high cycles (IDLE, READ, FETCH) before the next start bit.
REQ-021 A frame in progress SHALL complete unchanged when tx_enable falls or fifo_empty changes; no further read is issued while tx_enable=0.
REQ-022 fifo_empty=1 in IDLE: no strobe is issued and tx stays 1 indefinitely.
REQ-023 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, reload at 0 on each bit boundary, and never wrap mid-bit.
REQ-024 The latched byte SHALL not change between FETCH and the end of STOP, whatever fifo_data does.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, tx=1, fifo_read=0, fifo_enable=0, busy=0, sent_count=0, and the shift register, bit index and baud counter are 0.
REQ-026 Reset mid-frame SHALL abort the frame, with tx=1 from the cycle after the reset edge and no partial count.
REQ-027 Reset during READ SHALL not extend the strobe; the popped byte is discarded.

Verification (CLKS_PER_BIT=4)
REQ-028 Single byte: FIFO holds 0x01, tx_enable=1 -> one strobe; tx = 0 (4 cycles), then bits 1,0,0,0,0,0,0,0 (4 cycles each), then 1 (4 cycles); sent_count=1; busy falls.
REQ-029 Burst: FIFO holds 0x01,0x02,0x04,0x80,0xFF,0x70,0x2C -> 7 strobes; each frame decodes correctly; 3-cycle inter-frame gap; sent_count=7; stops when empty=1.
REQ-030 Disabled: tx_enable=0 with FIFO holding 0x02,0x03 -> no strobe; tx=1; sent_count=0; on tx_enable=1, 0x02 then 0x03 sent.
REQ-031 Enable drop: tx_enable falls during data bit 3 of 0x55 -> 0x55 frame completes; no further strobe although the FIFO is non-empty.
REQ-032 Reset mid-frame: reset pulse during data bit 5 -> tx=1 the next cycle; sent_count=0; after release with tx_enable=1, the next FIFO byte is sent complete.
REQ-033 Wrap: sent_count preset via 65535 frames (or a forced value of 0xFFFF) -> the next completed frame gives 0x0000.
